// File: rtl/wb_write_arbiter_if.sv
// ============================================================================
// Module      : wb_write_arbiter_if
// Description : Bundle of the ALU/MDU writeback inputs, decode hazard probe,
//               and register-file write port used by wb_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wb_write_arbiter_if;
  // ALU writeback (always accepted)
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_stall;
  // MDU writeback (valid/ready handshake)
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  // Decode pending-write probe
  logic [4:0]  query_addr;
  logic        query_hit;
  // Register file write port
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  // Performance counter
  logic [31:0] perf_stall_cnt;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mdu_valid, mdu_addr, mdu_data,
    input  query_addr,
    output alu_stall, mdu_ready, query_hit,
    output write_en, write_addr, write_data,
    output perf_stall_cnt
  );

  // Producer / register-file side
  modport master (
    output alu_valid, alu_addr, alu_data,
    output mdu_valid, mdu_addr, mdu_data,
    output query_addr,
    input  alu_stall, mdu_ready, query_hit,
    input  write_en, write_addr, write_data,
    input  perf_stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/wb_write_arbiter.sv
// ============================================================================
// Module      : wb_write_arbiter
// Description : Merges single-cycle ALU writebacks and queued MDU results onto
//               the register file's single write port. ALU has priority; MDU
//               results wait in a DEPTH-entry FIFO, are cancelled by younger
//               ALU writes to the same register, and force an ALU stall when
//               the FIFO head starves for STARVE_MAX cycles.
//               Optional macro WB_PERF_EN enables the stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_write_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  wb_write_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // FIFO storage and bookkeeping
  logic [4:0]       ent_addr_q [DEPTH];
  logic [4:0]       ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Starvation tracking and stall FSM
  logic [STV_W-1:0] starve_q, starve_d;
  state_t           state_q, state_d;

  // Registered write port
  logic             write_en_q, write_en_d;
  logic [4:0]       write_addr_q, write_addr_d;
  logic [31:0]      write_data_q, write_data_d;

  // Per-cycle decisions
  logic             alu_eff;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic             head_vld;
  logic [DEPTH-1:0] match_vec;

  // Request qualification: r0 writes are dropped, ALU wins over the FIFO
  always_comb begin
    alu_eff    = bus.alu_valid && (bus.alu_addr != 5'd0);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(DEPTH));
    push       = bus.mdu_valid && !fifo_full && (bus.mdu_addr != 5'd0);
    pop        = !alu_eff && !fifo_empty;
    head_vld   = !fifo_empty && ent_vld_q[rd_ptr_q];
  end

  // FIFO next state: cancel older entries on ALU write, then pop, then push
  always_comb begin
    ent_vld_d  = ent_vld_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // Queued MDU results are older than the ALU instruction: drop them
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_eff && (ent_addr_q[i] == bus.alu_addr)) begin
        ent_vld_d[i] = 1'b0;
      end
    end

    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + PTR_W'(1);
    end

    // Push lands in a free slot, so it is never hit by this cycle's cancel
    if (push) begin
      ent_vld_d[wr_ptr_q]  = 1'b1;
      ent_addr_d[wr_ptr_q] = bus.mdu_addr;
      ent_data_d[wr_ptr_q] = bus.mdu_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Write port selection; address/data hold when nothing is written
  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (alu_eff) begin
      write_en_d   = 1'b1;
      write_addr_d = bus.alu_addr;
      write_data_d = bus.alu_data;
    end else if (pop && head_vld) begin
      write_en_d   = 1'b1;
      write_addr_d = ent_addr_q[rd_ptr_q];
      write_data_d = ent_data_q[rd_ptr_q];
    end
  end

  // Starvation counter: counts cycles a live head is passed over, saturating
  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (head_vld && (starve_q != STV_W'(STARVE_MAX))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  // Stall FSM: enter drain once the head has waited STARVE_MAX cycles,
  // leave the cycle after the FIFO is seen empty
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (starve_d == STV_W'(STARVE_MAX)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control state with synchronous reset; reset discards queued results
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      state_q      <= ST_RUN;
      write_en_q   <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      ent_vld_q    <= ent_vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      state_q      <= state_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  // Entry payload storage; contents are qualified by the valid bits
  always_ff @(posedge clk) begin
    ent_addr_q <= ent_addr_d;
    ent_data_q <= ent_data_d;
  end

  // Per-entry hazard match against the decode probe
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match_vec[gi] = ent_vld_q[gi] && (ent_addr_q[gi] == bus.query_addr);
  end

  assign bus.query_hit  = (bus.query_addr != 5'd0) && (|match_vec);
  assign bus.mdu_ready  = !fifo_full;
  assign bus.alu_stall  = (state_q == ST_DRAIN);
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;

`ifdef WB_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;

  // Stall-cycle counter, saturating at all-ones
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if ((state_q == ST_DRAIN) && (perf_cnt_q != 32'hFFFF_FFFF)) begin
      perf_cnt_d = perf_cnt_q + 32'd1;
    end
  end

  // Stall-cycle counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= 32'd0;
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  assign bus.perf_stall_cnt = perf_cnt_q;
`else
  assign bus.perf_stall_cnt = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
// ============================================================================
// Module      : tb_wb_write_arbiter
// Description : Self-checking bench for wb_write_arbiter. A queue-based model
//               predicts every output each cycle; directed scenarios add
//               hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_write_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   started;

  wb_write_arbiter_if bus ();

  wb_write_arbiter #(
    .DEPTH      (DEPTH),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit          m_stall;
  int          m_wait;
  longint      m_perf;

  function automatic bit m_hit(input logic [4:0] qa);
    if (qa == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].v && (mq[i].a == qa)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit   alu;
    bit   empty_before;
    bit   head_v;
    bit   popped;
    ent_t e;
    started = 1'b1;
    if (rst) begin
      mq.delete();
      m_we = 0; m_wa = 5'd0; m_wd = 32'd0;
      m_stall = 0; m_wait = 0; m_perf = 0;
    end else begin
      alu          = bus.alu_valid && (bus.alu_addr != 5'd0);
      empty_before = (mq.size() == 0);
      head_v       = !empty_before && mq[0].v;
      popped       = 1'b0;
      if (m_stall && m_perf < 64'hFFFF_FFFF) m_perf++;
      if (alu) begin
        foreach (mq[i]) begin
          if (mq[i].a == bus.alu_addr) begin
            e = mq[i]; e.v = 1'b0; mq[i] = e;
          end
        end
        m_we = 1; m_wa = bus.alu_addr; m_wd = bus.alu_data;
      end else if (!empty_before) begin
        e = mq.pop_front();
        popped = 1'b1;
        m_we = e.v;
        if (e.v) begin m_wa = e.a; m_wd = e.d; end
      end else begin
        m_we = 0;
      end
      if (popped || empty_before) m_wait = 0;
      else if (head_v && m_wait < STARVE_MAX) m_wait++;
      if (m_stall) m_stall = !empty_before;
      else         m_stall = (m_wait == STARVE_MAX);
      // push is judged against occupancy before this cycle's pop
      if (bus.mdu_valid && (mq.size() + (popped ? 1 : 0)) < DEPTH && bus.mdu_addr != 5'd0)
        mq.push_back('{a: bus.mdu_addr, d: bus.mdu_data, v: 1'b1});
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("m_write_en",   32'(bus.write_en),   32'(m_we));
      check("m_write_addr", 32'(bus.write_addr), 32'(m_wa));
      check("m_write_data", bus.write_data,      m_wd);
      check("m_mdu_ready",  32'(bus.mdu_ready),  32'(mq.size() < DEPTH));
      check("m_alu_stall",  32'(bus.alu_stall),  32'(m_stall));
      check("m_query_hit",  32'(bus.query_hit),  32'(m_hit(bus.query_addr)));
`ifdef WB_PERF_EN
      check("m_perf",       bus.perf_stall_cnt,  m_perf[31:0]);
`else
      check("m_perf",       bus.perf_stall_cnt,  32'h0);
`endif
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_addr = 5'd0; bus.alu_data = 32'd0;
    bus.mdu_valid = 1'b0; bus.mdu_addr = 5'd0; bus.mdu_data = 32'd0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = 1'b1; bus.alu_addr = a; bus.alu_data = d;
  endtask

  task automatic mdu(input logic [4:0] a, input logic [31:0] d);
    bus.mdu_valid = 1'b1; bus.mdu_addr = a; bus.mdu_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int seen;
    checks = 0; errors = 0; started = 1'b0;
    rst = 1'b1;
    bus.query_addr = 5'd0;
    idle();
    cyc(); cyc();
    check("reset_write_en",  32'(bus.write_en),  32'd0);
    check("reset_mdu_ready", 32'(bus.mdu_ready), 32'd1);
    check("reset_alu_stall", 32'(bus.alu_stall), 32'd0);
    check("reset_perf",      bus.perf_stall_cnt, 32'd0);
    rst = 1'b0;
    cyc();

    // 1: ALU only, one-cycle latency
    alu(5'd5, 32'hDEAD_BEEF);
    cyc();
    check("t1_we",   32'(bus.write_en),   32'd1);
    check("t1_addr", 32'(bus.write_addr), 32'd5);
    check("t1_data", bus.write_data,      32'hDEAD_BEEF);
    idle();
    cyc();
    check("t1_we_off",   32'(bus.write_en),   32'd0);
    check("t1_addr_hold", 32'(bus.write_addr), 32'd5);

    // 2: fill FIFO while ALU busy, then drain in order
    for (int i = 1; i <= 4; i++) begin
      alu(5'd9, 32'h100 + 32'(i));
      mdu(5'(i), 32'hA0 + 32'(i));
      cyc();
    end
    check("t2_full", 32'(bus.mdu_ready), 32'd0);
    idle();
    for (int i = 1; i <= 4; i++) begin
      cyc();
      check("t2_drain_we",   32'(bus.write_en),   32'd1);
      check("t2_drain_addr", 32'(bus.write_addr), 32'(i));
      check("t2_drain_data", bus.write_data,      32'hA0 + 32'(i));
    end
    cyc();
    check("t2_empty_we", 32'(bus.write_en), 32'd0);

    // 3: WAW cancellation
    bus.query_addr = 5'd7;
    mdu(5'd7, 32'h77);
    cyc();
    check("t3_hit_before", 32'(bus.query_hit), 32'd1);
    idle();
    alu(5'd7, 32'h1);
    cyc();
    check("t3_alu_we",    32'(bus.write_en),  32'd1);
    check("t3_alu_data",  bus.write_data,     32'h1);
    check("t3_hit_after", 32'(bus.query_hit), 32'd0);
    idle();
    cyc();
    check("t3_cancel_we",   32'(bus.write_en), 32'd0);
    check("t3_cancel_data", bus.write_data,    32'h1);
    bus.query_addr = 5'd0;
    cyc();

    // 4: starvation forces a stall, entry drains, stall releases
    alu(5'd3, 32'h33);
    mdu(5'd12, 32'h00C0_FFEE);
    cyc();
    bus.mdu_valid = 1'b0;
    n = 0; seen = 0;
    while (n < 20 && seen == 0) begin
      n++;
      cyc();
      if (bus.alu_stall) seen = n;
    end
    check("t4_wait_cycles", 32'(seen), 32'd8);
    idle();
    cyc();
    check("t4_we",    32'(bus.write_en),   32'd1);
    check("t4_addr",  32'(bus.write_addr), 32'd12);
    check("t4_data",  bus.write_data,      32'h00C0_FFEE);
    check("t4_stall_hold", 32'(bus.alu_stall), 32'd1);
    cyc();
    check("t4_stall_off", 32'(bus.alu_stall), 32'd0);
`ifdef WB_PERF_EN
    check("t4_perf", bus.perf_stall_cnt, 32'd2);
`else
    check("t4_perf", bus.perf_stall_cnt, 32'd0);
`endif

    // 5: register 0 requests are ignored
    for (int i = 0; i < 3; i++) begin
      alu(5'd0, 32'hBAD0 + 32'(i));
      mdu(5'd0, 32'hBAD8 + 32'(i));
      cyc();
      check("t5_we",    32'(bus.write_en),  32'd0);
      check("t5_ready", 32'(bus.mdu_ready), 32'd1);
    end
    idle();
    cyc();
    check("t5_no_drain", 32'(bus.write_en), 32'd0);

    // 6: reset mid-drain discards queue
    for (int i = 0; i < 3; i++) begin
      alu(5'd20, 32'h200 + 32'(i));
      mdu(5'(21 + i), 32'h300 + 32'(i));
      cyc();
    end
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("t6_we",    32'(bus.write_en),  32'd0);
    check("t6_ready", 32'(bus.mdu_ready), 32'd1);
    for (int a = 0; a < 32; a++) begin
      bus.query_addr = 5'(a);
      cyc();
      check("t6_hit", 32'(bus.query_hit), 32'd0);
      check("t6_no_write", 32'(bus.write_en), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Write-side driver for the 32x32 register file. Merges writeback results from the single-cycle ALU path and the multi-cycle unit (MDU: mul/div) into the file's single write port (write_en/write_addr/write_data).
- The ALU path is unbuffered and has priority. MDU results queue in a small FIFO and drain on idle ALU cycles.
- Reports pending-write hazards to decode, and throttles the ALU when an MDU result starves.

Parameters:
DEPTH, 4, MDU result FIFO entries (power of 2, >=2)
STARVE_MAX, 8, consecutive cycles a valid FIFO head may wait before alu_stall asserts

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU writeback request this cycle (always accepted)
alu_addr  in  5  ALU destination register
alu_data  in  32  ALU result
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  FIFO can accept; transfer when mdu_valid && mdu_ready
mdu_addr  in  5  MDU destination register
mdu_data  in  32  MDU result
alu_stall  out  1  registered; upstream must hold alu_valid=0 while high
query_addr  in  5  decode source-register probe
query_hit  out  1  combinational; a valid FIFO entry targets query_addr
write_en  out  1  register file write enable, registered
write_addr  out  5  register file write address, registered
write_data  out  32  register file write data, registered
perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge) sets:
  - write_en=0, write_addr=0, write_data=0, alu_stall=0, starve counter=0, perf_stall_cnt=0.
  - FIFO empty, all entry valid bits cleared.
  - A reset in mid-drain discards all queued results.
- Register 0 filter:
  - ALU request with alu_addr=0 is treated as alu_valid=0.
  - MDU transfer with mdu_addr=0 is accepted (handshake completes) but not enqueued.
- Output latency: 1 cycle. The selected request at edge N appears on write_* during cycle N+1. write_en=0 on cycles with no selected request; write_addr/write_data then hold their last values.
- Selection each cycle:
  - Effective ALU request (alu_valid && alu_addr!=0) present: ALU wins; the FIFO does not pop.
  - Otherwise, FIFO non-empty: pop head and write it.
  - Otherwise: write_en=0.
- WAW cancellation: an effective ALU write to address A clears the valid bit of every FIFO entry with addr A. Queued MDU results are older than the ALU instruction.
  - Invalid entries still occupy slots; when popped they produce write_en=0.
  - An MDU result enqueued in the same cycle to address A is NOT cancelled.
- FIFO:
  - mdu_ready = !full.
  - Simultaneous push and pop when full is not allowed (ready is already low).
  - Push and pop in the same cycle when partially full keeps the count unchanged.
  - Pointers wrap modulo DEPTH; occupancy counter is 0..DEPTH.
- query_hit: OR over valid entries of (addr==query_addr). Forced to 0 when query_addr=0. Does not include the cycle's incoming push.
- Starvation control:
  - Counter increments each cycle the FIFO head is valid and not popped. Clears on pop or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, alu_stall=1 from the next cycle.
  - While alu_stall=1, the FIFO pops every cycle. alu_stall deasserts the cycle after the FIFO becomes empty.
  - If alu_valid is asserted while alu_stall=1 (protocol violation), the ALU still wins.

Optional Feature:
WB_PERF_EN
- Defined: perf_stall_cnt increments by 1 each cycle alu_stall=1. Saturates at 32'hFFFFFFFF. Cleared by rst.
- Undefined: perf_stall_cnt tied to 32'h0; no counter logic.

Test Plan:
1. ALU only: alu_valid=1, addr=5, data=32'hDEADBEEF at edge N -> write_en=1, write_addr=5, write_data=32'hDEADBEEF during N+1; write_en=0 during N+2.
2. Fill FIFO: 4 MDU pushes (addr 1..4) while ALU busy with addr 9 -> mdu_ready=0 after the 4th push; when ALU idles, writes 1,2,3,4 appear on consecutive cycles.
3. WAW: MDU result queued for addr 7, then ALU writes addr 7 = 32'h1 -> only one write to r7 (32'h1); the popped entry yields write_en=0; query_hit(7) drops to 0 one cycle after the ALU write.
4. Starvation: one MDU entry queued, alu_valid=1 continuously, STARVE_MAX=8 -> alu_stall=1 after 8 wait cycles; ALU held low -> entry written; alu_stall=0 the next cycle; perf_stall_cnt=2 (WB_PERF_EN).
5. r0: alu_addr=0 and mdu_addr=0 requests -> write_en stays 0; FIFO count stays 0; mdu_ready stays 1.
6. Reset mid-drain: 3 entries queued, rst=1 for one cycle -> write_en=0, mdu_ready=1, query_hit=0 for all addresses; no queued write appears afterwards.
